// File: rtl/agu_bank.sv
// Multi-register address generation unit: NREG address registers with whole/byte load,
// byte read-back, and address emit with post-increment, pre-decrement or signed-offset modify.
module agu_bank #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned NREG   = 4,
  parameter int unsigned STRIDE = 1,
  localparam int unsigned NB    = AW / DW,
  localparam int unsigned SW    = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    op,
  input  logic [SW-1:0] sel,
  input  logic [BW-1:0] bsel,
  input  logic [AW-1:0] abi,
  input  logic [DW-1:0] dbi,
  output logic [AW-1:0] abo,
  output logic          abo_en,
  output logic [DW-1:0] dbo,
  output logic          dbo_en,
  output logic          wrap
);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_WRB      = 3'd2,
    OP_RDB      = 3'd3,
    OP_EMIT     = 3'd4,
    OP_EMIT_INC = 3'd5,
    OP_EMIT_DEC = 3'd6,
    OP_ADD      = 3'd7
  } op_e;

  logic [AW-1:0] reg_q [NREG];
  logic [AW-1:0] reg_d [NREG];
  logic [AW-1:0] abo_q, abo_d;
  logic [DW-1:0] dbo_q, dbo_d;
  logic          abo_en_q, abo_en_d;
  logic          dbo_en_q, dbo_en_d;
  logic          wrap_q, wrap_d;

  logic [AW-1:0] cur;
  logic          sel_ok;
  logic [DW-1:0] lane;
  logic          lane_ok;
  logic [AW-1:0] wrb_val;
  logic [AW:0]   inc_sum;
  logic [AW-1:0] dec_val;
  logic [AW:0]   add_sum;
  logic [AW-1:0] wr_val;
  logic          wr_en;

  // Operand selection, modify arithmetic and next-state decode
  always_comb begin
    reg_d    = reg_q;
    abo_d    = abo_q;
    dbo_d    = dbo_q;
    abo_en_d = 1'b0;
    dbo_en_d = 1'b0;
    wrap_d   = 1'b0;
    cur      = '0;
    sel_ok   = 1'b0;
    lane     = '0;
    lane_ok  = 1'b0;
    wr_val   = '0;
    wr_en    = 1'b0;

    for (int unsigned r = 0; r < NREG; r++) begin
      if (32'(sel) == r) begin
        cur    = reg_q[r];
        sel_ok = 1'b1;
      end
    end

    wrb_val = cur;
    for (int unsigned b = 0; b < NB; b++) begin
      if (32'(bsel) == b) begin
        lane                 = cur[b*DW +: DW];
        lane_ok              = 1'b1;
        wrb_val[b*DW +: DW]  = dbi;
      end
    end

    inc_sum = {1'b0, cur} + (AW+1)'(STRIDE);
    dec_val = cur - AW'(STRIDE);
    // Offset is sign-extended; carry out means wrap for positive, no-carry means borrow for negative
    add_sum = {1'b0, cur} + {1'b0, AW'($signed(dbi))};

    if (sel_ok) begin
      case (op_e'(op))
        OP_LOAD: begin
          wr_en  = 1'b1;
          wr_val = abi;
        end
        OP_WRB: begin
          wr_en  = lane_ok;
          wr_val = wrb_val;
        end
        OP_RDB: begin
          dbo_d    = lane_ok ? lane : '0;
          dbo_en_d = 1'b1;
        end
        OP_EMIT: begin
          abo_d    = cur;
          abo_en_d = 1'b1;
        end
        OP_EMIT_INC: begin
          abo_d    = cur;
          abo_en_d = 1'b1;
          wr_en    = 1'b1;
          wr_val   = inc_sum[AW-1:0];
          wrap_d   = inc_sum[AW];
        end
        OP_EMIT_DEC: begin
          abo_d    = dec_val;
          abo_en_d = 1'b1;
          wr_en    = 1'b1;
          wr_val   = dec_val;
          wrap_d   = (cur < AW'(STRIDE));
        end
        OP_ADD: begin
          wr_en  = 1'b1;
          wr_val = add_sum[AW-1:0];
          wrap_d = dbi[DW-1] ? ~add_sum[AW] : add_sum[AW];
        end
        default: ;
      endcase
    end

    for (int unsigned r = 0; r < NREG; r++) begin
      if (wr_en && (32'(sel) == r)) reg_d[r] = wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q    <= '{default: '0};
      abo_q    <= '0;
      dbo_q    <= '0;
      abo_en_q <= 1'b0;
      dbo_en_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      reg_q    <= reg_d;
      abo_q    <= abo_d;
      dbo_q    <= dbo_d;
      abo_en_q <= abo_en_d;
      dbo_en_q <= dbo_en_d;
      wrap_q   <= wrap_d;
    end
  end

  assign abo    = abo_q;
  assign abo_en = abo_en_q;
  assign dbo    = dbo_q;
  assign dbo_en = dbo_en_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_agu_bank.sv
// Self-checking bench for agu_bank: directed + random ops against an integer reference model,
// plus a second instance (AW=32, NREG=3) for wide-lane and out-of-range select cases.
module tb_agu_bank;

  localparam int unsigned STRIDE = 1;
  localparam int          MOD    = 65536;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Default instance: AW=16, DW=8, NREG=4
  logic [2:0]  op;
  logic [1:0]  sel;
  logic        bsel;
  logic [15:0] abi;
  logic [7:0]  dbi;
  logic [15:0] abo;
  logic        abo_en;
  logic [7:0]  dbo;
  logic        dbo_en;
  logic        wrap;

  // Wide instance: AW=32, DW=8, NREG=3
  logic [2:0]  op2;
  logic [1:0]  sel2;
  logic [1:0]  bsel2;
  logic [31:0] abi2;
  logic [7:0]  dbi2;
  logic [31:0] abo2;
  logic        abo2_en;
  logic [7:0]  dbo2;
  logic        dbo2_en;
  logic        wrap2;

  agu_bank #(.AW(16), .DW(8), .NREG(4), .STRIDE(STRIDE)) u_dut (
    .clk(clk), .rst(rst), .op(op), .sel(sel), .bsel(bsel), .abi(abi), .dbi(dbi),
    .abo(abo), .abo_en(abo_en), .dbo(dbo), .dbo_en(dbo_en), .wrap(wrap)
  );

  agu_bank #(.AW(32), .DW(8), .NREG(3), .STRIDE(1)) u_dut2 (
    .clk(clk), .rst(rst), .op(op2), .sel(sel2), .bsel(bsel2), .abi(abi2), .dbi(dbi2),
    .abo(abo2), .abo_en(abo2_en), .dbo(dbo2), .dbo_en(dbo2_en), .wrap(wrap2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_reg [4];
  int m_abo, m_dbo;
  int m_abo_en, m_dbo_en, m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_abo = 0; m_dbo = 0; m_abo_en = 0; m_dbo_en = 0; m_wrap = 0;
  endtask

  task automatic model_op(input int o, input int s, input int b, input int a, input int d);
    int r, sum, off;
    m_abo_en = 0; m_dbo_en = 0; m_wrap = 0;
    r = m_reg[s];
    case (o)
      1: r = a;
      2: r = (r & ~(255 << (8*b))) | (d << (8*b));
      3: begin m_dbo = (r >> (8*b)) & 255; m_dbo_en = 1; end
      4: begin m_abo = r; m_abo_en = 1; end
      5: begin
        m_abo = r; m_abo_en = 1;
        sum = r + STRIDE;
        m_wrap = (sum >= MOD) ? 1 : 0;
        r = sum % MOD;
      end
      6: begin
        m_wrap = (r < STRIDE) ? 1 : 0;
        r = (r - STRIDE + MOD) % MOD;
        m_abo = r; m_abo_en = 1;
      end
      7: begin
        off = (d >= 128) ? d - 256 : d;
        sum = r + off;
        m_wrap = (sum < 0 || sum >= MOD) ? 1 : 0;
        r = (sum + MOD) % MOD;
      end
      default: ;
    endcase
    m_reg[s] = r;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".abo"},    32'(abo),    32'(m_abo));
    chk({ctx, ".abo_en"}, 32'(abo_en), 32'(m_abo_en));
    chk({ctx, ".dbo"},    32'(dbo),    32'(m_dbo));
    chk({ctx, ".dbo_en"}, 32'(dbo_en), 32'(m_dbo_en));
    chk({ctx, ".wrap"},   32'(wrap),   32'(m_wrap));
  endtask

  task automatic step(input int o, input int s, input int b, input int a, input int d);
    @(negedge clk);
    op = 3'(o); sel = 2'(s); bsel = 1'(b); abi = 16'(a); dbi = 8'(d);
    model_op(o, s, b, a, d);
    @(posedge clk);
    #1;
    check_outputs($sformatf("op%0d_sel%0d", o, s));
  endtask

  task automatic step2(input int o, input int s, input int b, input logic [31:0] a, input int d,
                       input logic [31:0] e_abo, input int e_aen, input int e_dbo,
                       input int e_den, input int e_wrap);
    @(negedge clk);
    op2 = 3'(o); sel2 = 2'(s); bsel2 = 2'(b); abi2 = a; dbi2 = 8'(d);
    @(posedge clk);
    #1;
    chk($sformatf("w_op%0d_sel%0d.abo", o, s),    abo2,          e_abo);
    chk($sformatf("w_op%0d_sel%0d.abo_en", o, s), 32'(abo2_en),  32'(e_aen));
    chk($sformatf("w_op%0d_sel%0d.dbo", o, s),    32'(dbo2),     32'(e_dbo));
    chk($sformatf("w_op%0d_sel%0d.dbo_en", o, s), 32'(dbo2_en),  32'(e_den));
    chk($sformatf("w_op%0d_sel%0d.wrap", o, s),   32'(wrap2),    32'(e_wrap));
  endtask

  initial begin
    int o, s, b, a, d;
    rst = 1'b1;
    op = '0; sel = '0; bsel = '0; abi = '0; dbi = '0;
    op2 = '0; sel2 = '0; bsel2 = '0; abi2 = '0; dbi2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed sequence
    for (int i = 0; i < 4; i++) step(4, i, 0, 0, 0);
    step(1, 1, 0, 16'h1234, 0);
    step(3, 1, 0, 0, 0);
    step(3, 1, 1, 0, 0);
    step(1, 2, 0, 16'h00FF, 0);
    step(2, 2, 1, 0, 8'hAB);
    step(4, 2, 0, 0, 0);
    step(4, 1, 0, 0, 0);
    step(1, 0, 0, 16'hFFFF, 0);
    step(5, 0, 0, 0, 0);
    step(5, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0);
    step(1, 3, 0, 16'h0000, 0);
    step(6, 3, 0, 0, 0);
    step(1, 1, 0, 16'h0100, 0);
    step(7, 1, 0, 0, 8'h80);
    step(4, 1, 0, 0, 0);
    step(1, 0, 0, 16'hFFFF, 0);
    step(7, 0, 0, 0, 8'h01);
    step(4, 0, 0, 0, 0);

    // Randomised ops, biased toward wrap boundaries for loads
    for (int i = 0; i < 400; i++) begin
      o = int'($urandom_range(7, 0));
      s = int'($urandom_range(3, 0));
      b = int'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0: a = 16'hFFFF;
        1: a = 0;
        default: a = int'($urandom & 32'hFFFF);
      endcase
      d = int'($urandom & 32'hFF);
      step(o, s, b, a, d);
    end

    // Reset mid-stream discards the op presented in the same cycle
    @(negedge clk);
    rst = 1'b1;
    op = 3'd1; sel = 2'd0; abi = 16'h5555;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    op = '0;
    for (int i = 0; i < 4; i++) step(4, i, 0, 0, 0);

    // Wide instance: 4 lanes, sel=3 out of range with NREG=3
    step2(1, 0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0, 0);
    step2(3, 0, 3, 32'h0, 0, 32'h0, 0, 8'hDE, 1, 0);
    step2(3, 0, 0, 32'h0, 0, 32'h0, 0, 8'hEF, 1, 0);
    step2(1, 3, 0, 32'h12345678, 0, 32'h0, 0, 8'hEF, 0, 0);
    step2(4, 0, 0, 32'h0, 0, 32'hDEADBEEF, 1, 8'hEF, 0, 0);
    step2(4, 1, 0, 32'h0, 0, 32'h0, 1, 8'hEF, 0, 0);
    step2(4, 2, 0, 32'h0, 0, 32'h0, 1, 8'hEF, 0, 0);
    step2(4, 3, 0, 32'h0, 0, 32'h0, 0, 8'hEF, 0, 0);
    step2(3, 3, 3, 32'h0, 0, 32'h0, 0, 8'hEF, 0, 0);
    step2(7, 3, 0, 32'h0, 8'hFF, 32'h0, 0, 8'hEF, 0, 0);
    step2(5, 0, 0, 32'h0, 0, 32'hDEADBEEF, 1, 8'hEF, 0, 0);
    step2(4, 0, 0, 32'h0, 0, 32'hDEADBEF0, 1, 8'hEF, 0, 0);
    step2(6, 1, 0, 32'h0, 0, 32'hFFFFFFFF, 1, 8'hEF, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
